risc8_mem_arbiter: RTL
======================

Name: risc8_mem_arbiter

Overview:
- Shares the single 16-bit/24-bit-address memory port of the risc8 core between two requesters: the CPU datapath (port c) and a DMA/debug master (port d).
- Issues at most one memory access per cycle, routes read data back to its owner after a fixed memory latency, and gives the CPU stall information.
- Supports a lock so multi-cycle sequences are not interleaved, e.g. a 16-bit stack push/pop split over two accesses.

Parameters:
- RD_LAT, 1: memory read latency in cycles, legal range 1..4.
- MAX_LOCK, 4: maximum consecutive locked grants before lock is forcibly released, legal range 2..15.
- CPU_PRIO, 0: 1 = fixed CPU priority on ties; 0 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- c_req  in  1  CPU access request
- c_we  in  1  CPU write enable
- c_lock  in  1  CPU requests lock after this access
- c_addr  in  24  CPU word address
- c_wdata  in  16  CPU write data
- c_gnt  out  1  CPU access accepted this cycle
- c_stall  out  1  c_req & ~c_gnt
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  16  CPU read data
- d_req, d_we, d_lock, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the c_ ports, DMA side (no stall output)
- m_en  out  1  memory access strobe
- m_we  out  1  memory write
- m_addr  out  24  memory address
- m_wdata  out  16  memory write data
- m_rdata  in  16  memory read data, valid RD_LAT cycles after issue

Behaviour:
- Requester rules: x_req, x_we, x_lock, x_addr and x_wdata are held stable from assertion until the cycle x_gnt=1. The bench asserts this.
- Grant timing: grant is combinational from the current requests and registered state. In the grant cycle: m_en=1, and m_we/m_addr/m_wdata carry the winner's values. When no grant is given, m_en=0 and m_we, m_addr, m_wdata are all 0.
- Exactly one or zero of c_gnt/d_gnt is high in any cycle.
- Winner selection, in priority order:
  - Only one requester: it wins, unless the other holds the lock.
  - Lock held (locked_q=1): lock_id wins when its req=1. The other requester is blocked even if lock_id's req=0.
  - Both request, no lock: CPU_PRIO=1 gives CPU; otherwise the requester that is not last_q wins.
- last_q updates to the winner on every grant. Reset value of last_q = d, so the CPU wins the first tie.
- Lock state (locked_q, lock_id, lock_cnt[3:0]) updates on a grant to X:
  - If x_lock=1 and lock_cnt+1 < MAX_LOCK: locked_q=1, lock_id=X, lock_cnt incremented.
  - Otherwise (lock=0, or MAX_LOCK reached): locked_q=0, lock_cnt=0.
- Forced release: when the lock ends because MAX_LOCK was reached, the other requester wins the next tie regardless of CPU_PRIO, for one arbitration only.
- Owner drops request: if lock_id drops req while locked, the lock is released at the end of that cycle (locked_q=0, lock_cnt=0). The other requester may win from the next cycle.
- Read return:
  - A shift register of depth RD_LAT carries {valid, owner} for each issued read. Writes insert valid=0.
  - In cycle N+RD_LAT after a read issued in cycle N, the owner sees x_rvalid=1 and x_rdata=m_rdata. The non-owner sees rvalid=0 and rdata=0.
  - Reads back-to-back every cycle are fully supported. Returns are in issue order.
- Writes produce no rvalid. A write and an earlier read's return may occur in the same cycle.
- Reset: all outputs 0; locked_q=0; lock_cnt=0; last_q=d; return pipeline cleared. Reads in flight when rst rises never produce rvalid.

Test Plan:
- Reset and tie: hold rst 2 cycles, all outputs 0. Then c_req=d_req=1 in the same cycle → c_gnt=1, d_gnt=0, c_stall=0, m_addr=c_addr.
- CPU read, RD_LAT=1: c_req=1, c_addr=0xFFFFFE → m_en=1, m_we=0, m_addr=0xFFFFFE. Next cycle m_rdata=0xA55A → c_rvalid=1, c_rdata=0xA55A, d_rvalid=0.
- Round-robin, CPU_PRIO=0: both req continuously with distinct addresses, no lock → grants alternate c,d,c,d for 8 cycles; c_stall=1 exactly on the d cycles.
- Lock limit, MAX_LOCK=4: c_lock=1 and both req continuously → c granted 4 consecutive cycles, d granted the 5th; with CPU_PRIO=1, d is still granted the 5th (forced release).
- Early unlock: c_lock=1 on the first grant and c_lock=0 on the second, d_req held → c,c,d. Repeat with c_req dropped after the first locked grant → d granted in the very next cycle.
- Reset mid-read, RD_LAT=3: d read granted in cycle 0, rst in cycle 1 → d_rvalid stays 0 through cycle 5. Then a CPU write: m_we=1, m_wdata=c_wdata=0x1234, and no rvalid follows.

Source files
------------

// File: rtl/risc8_mem_arbiter.sv
// risc8_mem_arbiter: shares the risc8 memory port between the CPU (c) and a DMA/debug master (d).
// One access per cycle, optional access locking, read data routed to its owner RD_LAT cycles later.
module risc8_mem_arbiter #(
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 4,
   parameter bit CPU_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req,
   input  logic        c_we,
   input  logic        c_lock,
   input  logic [23:0] c_addr,
   input  logic [15:0] c_wdata,
   output logic        c_gnt,
   output logic        c_stall,
   output logic        c_rvalid,
   output logic [15:0] c_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_lock,
   input  logic [23:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [15:0] d_rdata,
   output logic        m_en,
   output logic        m_we,
   output logic [23:0] m_addr,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata
);

   localparam logic ID_C = 1'b0;
   localparam logic ID_D = 1'b1;

   typedef struct packed {
      logic        we;
      logic        lock;
      logic [23:0] addr;
      logic [15:0] wdata;
   } req_t;

   req_t            c_r, d_r, win_r;
   logic            locked_q, lock_id_q, last_q, force_q;
   logic [3:0]      lock_cnt_q;
   logic            gnt, win_id, lock_ok;
   logic [RD_LAT:1] vld_pipe, own_pipe;
   logic            rd_vld, rd_own;

   assign c_r = {c_we, c_lock, c_addr, c_wdata};
   assign d_r = {d_we, d_lock, d_addr, d_wdata};

   // force_q makes the tie go to the non-holder after a lock hit MAX_LOCK, overriding CPU_PRIO once
   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!rst) begin
         if (locked_q) begin
            c_gnt = c_req & (lock_id_q == ID_C);
            d_gnt = d_req & (lock_id_q == ID_D);
         end else if (c_req && d_req) begin
            if (CPU_PRIO && !force_q)
               c_gnt = 1'b1;
            else if (last_q == ID_D)
               c_gnt = 1'b1;
            else
               d_gnt = 1'b1;
         end else begin
            c_gnt = c_req;
            d_gnt = d_req;
         end
      end
   end

   assign gnt     = c_gnt | d_gnt;
   assign win_id  = d_gnt;
   assign win_r   = d_gnt ? d_r : c_r;
   assign lock_ok = win_r.lock && (({1'b0, lock_cnt_q} + 5'd1) < 5'(MAX_LOCK));

   assign m_en    = gnt;
   assign m_we    = gnt & win_r.we;
   assign m_addr  = gnt ? win_r.addr  : 24'd0;
   assign m_wdata = gnt ? win_r.wdata : 16'd0;
   assign c_stall = c_req & ~c_gnt & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q   <= 1'b0;
         lock_id_q  <= ID_C;
         lock_cnt_q <= 4'd0;
         last_q     <= ID_D;
         force_q    <= 1'b0;
      end else if (gnt) begin
         last_q  <= win_id;
         force_q <= win_r.lock & ~lock_ok;
         if (lock_ok) begin
            locked_q   <= 1'b1;
            lock_id_q  <= win_id;
            lock_cnt_q <= lock_cnt_q + 4'd1;
         end else begin
            locked_q   <= 1'b0;
            lock_cnt_q <= 4'd0;
         end
      end else if (locked_q) begin
         // no grant while locked means the holder dropped its request
         locked_q   <= 1'b0;
         lock_cnt_q <= 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         own_pipe <= '0;
      end else begin
         vld_pipe[1] <= gnt & ~win_r.we;
         own_pipe[1] <= win_id;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            own_pipe[i] <= own_pipe[i-1];
         end
      end
   end

   assign rd_vld   = vld_pipe[RD_LAT] & ~rst;
   assign rd_own   = own_pipe[RD_LAT];
   assign c_rvalid = rd_vld & (rd_own == ID_C);
   assign d_rvalid = rd_vld & (rd_own == ID_D);
   assign c_rdata  = c_rvalid ? m_rdata : 16'd0;
   assign d_rdata  = d_rvalid ? m_rdata : 16'd0;

endmodule
